// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over an external single-port RAM with registered read data
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   s_valid/s_data  upstream word offer; s_ready high when the word is taken this cycle
//   m_valid/m_data  downstream word; m_ready takes it
//   ram_wr_rd       1 = write, 0 = read for the single RAM port
//   ram_addr        RAM address
//   ram_data_in     RAM write data
//   ram_data_out    registered RAM read data, valid one cycle after the read edge
//   level           words stored in RAM (not counting in-flight or output-register word)
//   full, empty     level == DEPTH / level == 0
module ram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [WIDTH-1:0]           m_data,
  input  logic                       m_ready,
  output logic                       ram_wr_rd,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  output logic [WIDTH-1:0]           ram_data_in,
  input  logic [WIDTH-1:0]           ram_data_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rd_go;
  logic          wr_go;

  assign level = count;
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A read may be issued only when the output register is free or being
  // emptied on this same edge, so the captured word always has a home.
  assign rd_go = (state == IDLE) && (count != '0) && (!m_valid || m_ready);

  // Reads own the RAM port when both want it; gating with rst keeps the
  // upstream stalled for the whole reset.
  assign s_ready = rst && !full && !rd_go;
  assign wr_go   = s_valid && s_ready;

  always_comb begin
    ram_wr_rd   = 1'b0;
    ram_addr    = rd_ptr;
    ram_data_in = '0;
    if (wr_go) begin
      ram_wr_rd   = 1'b1;
      ram_addr    = wr_ptr;
      ram_data_in = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      // rd_go and wr_go are mutually exclusive through s_ready.
      if (wr_go) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (rd_go) state <= RD_WAIT;
        end
        RD_WAIT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A capture wins over a same-edge consume: the new word replaces the old.
      if (state == RD_WAIT) begin
        m_valid <= 1'b1;
        m_data  <= ram_data_out;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
